// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: shares one 16x16 mask ROM among NUM_SPR sprites, prefetching rows in hblank.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN (adds iSprFlip).
module sprite_line_fetcher #(
  parameter int unsigned NUM_SPR = 4,
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 10
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iLineStart,
  input  logic [Y_W-1:0]           iNextLine,
  input  logic [NUM_SPR*X_W-1:0]   iSprX,
  input  logic [NUM_SPR*Y_W-1:0]   iSprY,
  input  logic [NUM_SPR-1:0]       iSprEnable,
`ifdef SPRITE_MIRROR_EN
  input  logic [NUM_SPR-1:0]       iSprFlip,
`endif
  input  logic [X_W-1:0]           iPixelX,
  input  logic                     iActive,
  output logic [7:0]               oRomAddress,
  input  logic                     iRomMask,
  output logic [NUM_SPR-1:0]       oHit,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oOverrun
);

  localparam int unsigned IdxW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SPR - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StFetch = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [IdxW-1:0]                  idx_q, idx_d;
  logic [3:0]                       col_q, col_d;
  logic [3:0]                       row_q, row_d;
  logic [7:0]                       addr_q, addr_d;
  logic [Y_W-1:0]                   line_q, line_d;
  logic [NUM_SPR-1:0][X_W-1:0]      spr_x_q, spr_x_d;
  logic [NUM_SPR-1:0][Y_W-1:0]      spr_y_q, spr_y_d;
  logic [NUM_SPR-1:0]               spr_en_q, spr_en_d;
  logic [NUM_SPR-1:0][15:0]         shadow_row_q, shadow_row_d;
  logic [NUM_SPR-1:0][X_W-1:0]      shadow_x_q, shadow_x_d;
  logic [NUM_SPR-1:0]               shadow_valid_q, shadow_valid_d;
  logic [NUM_SPR-1:0][15:0]         active_row_q, active_row_d;
  logic [NUM_SPR-1:0][X_W-1:0]      active_x_q, active_x_d;
  logic [NUM_SPR-1:0]               active_valid_q, active_valid_d;
  logic [NUM_SPR-1:0]               hit_q, hit_d;
  logic                             done_q, done_d;
  logic                             overrun_q, overrun_d;

  logic [NUM_SPR-1:0][X_W-1:0]      spr_x_in;
  logic [NUM_SPR-1:0][Y_W-1:0]      spr_y_in;
  logic [Y_W:0]                     cur_dy;
  logic                             cur_hit;
  logic [3:0]                       fetch_col;
  logic [7:0]                       fetch_addr;

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_unpack
    assign spr_x_in[g] = iSprX[g*X_W +: X_W];
    assign spr_y_in[g] = iSprY[g*Y_W +: Y_W];
  end

`ifdef SPRITE_MIRROR_EN
  logic [NUM_SPR-1:0] spr_flip_q, spr_flip_d;

  always_comb begin
    spr_flip_d = spr_flip_q;
    if (iLineStart) spr_flip_d = iSprFlip;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) spr_flip_q <= '0;
    else        spr_flip_q <= spr_flip_d;
  end

  // Reading column 15-col while writing column col mirrors the row.
  assign fetch_col = spr_flip_q[idx_q] ? ~col_q : col_q;
`else
  assign fetch_col = col_q;
`endif

  assign fetch_addr = {row_q, fetch_col};

  // Extra sign bit: a line above the sprite top yields a negative dy.
  assign cur_dy  = {1'b0, line_q} - {1'b0, spr_y_q[idx_q]};
  assign cur_hit = spr_en_q[idx_q] && !cur_dy[Y_W] && (cur_dy[Y_W-1:4] == '0);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    col_d          = col_q;
    row_d          = row_q;
    addr_d         = addr_q;
    line_d         = line_q;
    spr_x_d        = spr_x_q;
    spr_y_d        = spr_y_q;
    spr_en_d       = spr_en_q;
    shadow_row_d   = shadow_row_q;
    shadow_x_d     = shadow_x_q;
    shadow_valid_d = shadow_valid_q;
    active_row_d   = active_row_q;
    active_x_d     = active_x_q;
    active_valid_d = active_valid_q;
    done_d         = 1'b0;
    overrun_d      = 1'b0;

    case (state_q)
      StCheck: begin
        if (cur_hit) begin
          row_d   = cur_dy[3:0];
          col_d   = 4'd0;
          state_d = StFetch;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StFetch: begin
        addr_d                     = fetch_addr;
        shadow_row_d[idx_q][col_q] = iRomMask;
        col_d                      = col_q + 4'd1;
        if (col_q == 4'd15) begin
          shadow_valid_d[idx_q] = 1'b1;
          shadow_x_d[idx_q]     = spr_x_q[idx_q];
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StCheck;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: ;
    endcase

    // A new line always wins; an unfinished fetch is dropped and the line shows no sprites.
    if (iLineStart) begin
      active_row_d = shadow_row_q;
      active_x_d   = shadow_x_q;
      if (state_q != StIdle) begin
        overrun_d      = 1'b1;
        active_valid_d = '0;
      end else begin
        active_valid_d = shadow_valid_q;
      end
      line_d         = iNextLine;
      spr_x_d        = spr_x_in;
      spr_y_d        = spr_y_in;
      spr_en_d       = iSprEnable;
      shadow_valid_d = '0;
      idx_d          = '0;
      state_d        = StCheck;
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
    logic [X_W:0] dx;
    assign dx       = {1'b0, iPixelX} - {1'b0, active_x_q[g]};
    assign hit_d[g] = iActive && active_valid_q[g] && !dx[X_W] && (dx[X_W-1:4] == '0) &&
                      active_row_q[g][dx[3:0]];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      col_q          <= '0;
      row_q          <= '0;
      addr_q         <= '0;
      line_q         <= '0;
      spr_x_q        <= '0;
      spr_y_q        <= '0;
      spr_en_q       <= '0;
      shadow_row_q   <= '0;
      shadow_x_q     <= '0;
      shadow_valid_q <= '0;
      active_row_q   <= '0;
      active_x_q     <= '0;
      active_valid_q <= '0;
      hit_q          <= '0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      col_q          <= col_d;
      row_q          <= row_d;
      addr_q         <= addr_d;
      line_q         <= line_d;
      spr_x_q        <= spr_x_d;
      spr_y_q        <= spr_y_d;
      spr_en_q       <= spr_en_d;
      shadow_row_q   <= shadow_row_d;
      shadow_x_q     <= shadow_x_d;
      shadow_valid_q <= shadow_valid_d;
      active_row_q   <= active_row_d;
      active_x_q     <= active_x_d;
      active_valid_q <= active_valid_d;
      hit_q          <= hit_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
    end
  end

  // The ROM is combinational, so the address is live during FETCH and held otherwise.
  assign oRomAddress = (state_q == StFetch) ? fetch_addr : addr_q;
  assign oHit        = hit_q;
  assign oBusy       = (state_q == StCheck) || (state_q == StFetch);
  assign oDone       = done_q;
  assign oOverrun    = overrun_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: directed and random scanlines against a line-level sprite model.
module tb_sprite_line_fetcher;

  localparam int NS = 4;
  localparam int XW = 10;
  localparam int YW = 10;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              iLineStart;
  logic [YW-1:0]     iNextLine;
  logic [NS*XW-1:0]  iSprX;
  logic [NS*YW-1:0]  iSprY;
  logic [NS-1:0]     iSprEnable;
`ifdef SPRITE_MIRROR_EN
  logic [NS-1:0]     iSprFlip;
`endif
  logic [XW-1:0]     iPixelX;
  logic              iActive;
  logic [7:0]        oRomAddress;
  logic              iRomMask;
  logic [NS-1:0]     oHit;
  logic              oBusy;
  logic              oDone;
  logic              oOverrun;

  sprite_line_fetcher #(
    .NUM_SPR (NS),
    .X_W     (XW),
    .Y_W     (YW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iLineStart  (iLineStart),
    .iNextLine   (iNextLine),
    .iSprX       (iSprX),
    .iSprY       (iSprY),
    .iSprEnable  (iSprEnable),
`ifdef SPRITE_MIRROR_EN
    .iSprFlip    (iSprFlip),
`endif
    .iPixelX     (iPixelX),
    .iActive     (iActive),
    .oRomAddress (oRomAddress),
    .iRomMask    (iRomMask),
    .oHit        (oHit),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oOverrun    (oOverrun)
  );

  always #5 Clock = ~Clock;

  logic rom_mem [256];
  assign iRomMask = rom_mem[oRomAddress];

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Sprite attributes as presented on the inputs
  int        spr_x [NS];
  int        spr_y [NS];
  bit        spr_en [NS];
  bit        spr_flip [NS];
  // Line buffers as the model expects them
  bit        pend_valid [NS];
  int        pend_x [NS];
  bit [15:0] pend_row [NS];
  bit        act_valid [NS];
  int        act_x [NS];
  bit [15:0] act_row [NS];
  bit        pend_open;
  int        start_cyc;
  int        exp_lat;
  logic [7:0] addr_q [$];

  int checks = 0;
  int errors = 0;
  int hit0_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_sprites();
    for (int i = 0; i < NS; i++) begin
      iSprX[i*XW +: XW] = XW'(spr_x[i]);
      iSprY[i*YW +: YW] = YW'(spr_y[i]);
      iSprEnable[i]     = spr_en[i];
`ifdef SPRITE_MIRROR_EN
      iSprFlip[i]       = spr_flip[i];
`endif
    end
  endtask

  task automatic step();
    @(negedge Clock);
    if (oBusy === 1'b1 && addr_q.size() > 0 && oRomAddress === addr_q[0]) void'(addr_q.pop_front());
    if (oDone === 1'b1) begin
      chk("done_expected", 64'(pend_open), 64'd1);
      if (pend_open) begin
        chk("done_latency", 64'(cyc - start_cyc), 64'(exp_lat));
        chk("busy_at_done", 64'(oBusy), 64'd0);
        chk("rom_addr_missing", 64'(addr_q.size()), 64'd0);
        pend_open = 1'b0;
      end
    end
  endtask

  task automatic start_line(input int line);
    logic exp_ovr;
    int   lat;
    int   dy;
    int   src;
    exp_ovr = pend_open;
    for (int i = 0; i < NS; i++) begin
      act_x[i]     = pend_x[i];
      act_row[i]   = pend_row[i];
      act_valid[i] = pend_open ? 1'b0 : pend_valid[i];
    end
    addr_q.delete();
    lat = 1;
    for (int i = 0; i < NS; i++) begin
      pend_valid[i] = 1'b0;
      dy = line - spr_y[i];
      if (spr_en[i] && dy >= 0 && dy < 16) begin
        pend_valid[i] = 1'b1;
        pend_x[i]     = spr_x[i];
        for (int c = 0; c < 16; c++) begin
          src            = spr_flip[i] ? 15 - c : c;
          pend_row[i][c] = rom_mem[dy*16 + src];
          addr_q.push_back(8'(dy*16 + src));
        end
        lat += 17;
      end else begin
        lat += 1;
      end
    end
    pend_open  = 1'b0;
    iNextLine  = YW'(line);
    iLineStart = 1'b1;
    step();
    iLineStart = 1'b0;
    start_cyc  = cyc;
    exp_lat    = lat;
    pend_open  = 1'b1;
    chk("overrun", 64'(oOverrun), 64'(exp_ovr));
    chk("busy_after_start", 64'(oBusy), 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (pend_open && n < 300) begin
      step();
      n++;
    end
    chk("done_timeout", 64'(pend_open), 64'd0);
    pend_open = 1'b0;
  endtask

  function automatic logic [NS-1:0] model_hit(input int x, input logic act);
    logic [NS-1:0] r;
    int dx;
    for (int i = 0; i < NS; i++) begin
      dx   = x - act_x[i];
      r[i] = act && act_valid[i] && dx >= 0 && dx < 16 && act_row[i][dx];
    end
    return r;
  endfunction

  task automatic sweep(input int lo, input int hi, input bit rnd_act);
    logic [NS-1:0] exp;
    for (int x = lo; x <= hi; x++) begin
      if (x < 0 || x > 1023) continue;
      iPixelX = XW'(x);
      iActive = rnd_act ? ($urandom_range(0, 7) != 0) : 1'b1;
      exp     = model_hit(x, iActive);
      step();
      chk("hit", 64'(oHit), 64'(exp));
      if (oHit[0] === 1'b1) hit0_cnt++;
    end
    iActive = 1'b0;
  endtask

  task automatic sweep_all_sprites();
    for (int i = 0; i < NS; i++) sweep(act_x[i] - 2, act_x[i] + 17, 1'b1);
  endtask

  task automatic rom_random();
    for (int a = 0; a < 256; a++) rom_mem[a] = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      pend_valid[i] = 1'b0;
      act_valid[i]  = 1'b0;
      pend_x[i]     = 0;
      act_x[i]      = 0;
      pend_row[i]   = '0;
      act_row[i]    = '0;
    end
    pend_open = 1'b0;
    addr_q.delete();
  endtask

  initial begin
    int line;
    int k;
    Reset      = 1'b0;
    iLineStart = 1'b0;
    iNextLine  = '0;
    iSprX      = '0;
    iSprY      = '0;
    iSprEnable = '0;
`ifdef SPRITE_MIRROR_EN
    iSprFlip   = '0;
`endif
    iPixelX    = '0;
    iActive    = 1'b0;
    for (int i = 0; i < NS; i++) begin
      spr_x[i] = 0; spr_y[i] = 0; spr_en[i] = 1'b0; spr_flip[i] = 1'b0;
    end
    clear_model();
    rom_random();

    // Reset values
    @(negedge Clock);
    @(negedge Clock);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_done", 64'(oDone), 64'd0);
    chk("rst_overrun", 64'(oOverrun), 64'd0);
    chk("rst_hit", 64'(oHit), 64'd0);
    chk("rst_addr", 64'(oRomAddress), 64'd0);
    Reset = 1'b1;
    step();

    // Single sprite, row pattern 1110000000000111
    for (int c = 0; c < 16; c++) rom_mem[c] = (c < 3 || c > 12);
    spr_x[0] = 100; spr_y[0] = 50; spr_en[0] = 1'b1;
    drive_sprites();
    start_line(50);
    wait_done();
    start_line(51);
    hit0_cnt = 0;
    sweep(98, 117, 1'b0);
    chk("pattern_hit_count", 64'(hit0_cnt), 64'd6);
    wait_done();

    // All four sprites on the line, including left and right screen edges
    rom_random();
    spr_x[0] = 0;   spr_x[1] = 200; spr_x[2] = 400; spr_x[3] = 1015;
    for (int i = 0; i < NS; i++) begin spr_y[i] = 10; spr_en[i] = 1'b1; end
    drive_sprites();
    start_line(10);
    wait_done();
    start_line(11);
    sweep_all_sprites();
    wait_done();

    // Rows just outside the sprite: dy = 16 and dy = -1
    for (int i = 0; i < NS; i++) spr_en[i] = 1'b0;
    spr_x[0] = 100; spr_y[0] = 50; spr_en[0] = 1'b1;
    drive_sprites();
    start_line(66);
    wait_done();
    start_line(49);
    hit0_cnt = 0;
    sweep(95, 120, 1'b0);
    wait_done();
    start_line(0);
    sweep(95, 120, 1'b0);
    chk("miss_hit_count", 64'(hit0_cnt), 64'd0);
    wait_done();

    // Overrun: new line 20 cycles into a full fetch
    spr_x[0] = 30; spr_x[1] = 90; spr_x[2] = 500; spr_x[3] = 700;
    for (int i = 0; i < NS; i++) begin spr_y[i] = 10; spr_en[i] = 1'b1; end
    drive_sprites();
    start_line(10);
    for (int n = 0; n < 19; n++) step();
    start_line(10);
    sweep_all_sprites();
    wait_done();
    start_line(11);
    sweep_all_sprites();
    wait_done();

    // Reset during FETCH
    start_line(12);
    for (int n = 0; n < 10; n++) step();
    Reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(oBusy), 64'd0);
    chk("midrst_hit", 64'(oHit), 64'd0);
    chk("midrst_done", 64'(oDone), 64'd0);
    clear_model();
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    step();
    chk("midrst_idle", 64'(oBusy), 64'd0);
    start_line(12);
    sweep_all_sprites();
    wait_done();
    start_line(13);
    sweep_all_sprites();
    wait_done();

`ifdef SPRITE_MIRROR_EN
    // Mirrored sprite, row pattern 1000000000000000
    for (int c = 0; c < 16; c++) rom_mem[c] = (c == 0);
    for (int i = 0; i < NS; i++) begin spr_en[i] = 1'b0; spr_flip[i] = 1'b0; end
    spr_x[0] = 300; spr_y[0] = 20; spr_en[0] = 1'b1; spr_flip[0] = 1'b1;
    drive_sprites();
    start_line(20);
    wait_done();
    start_line(21);
    hit0_cnt = 0;
    sweep(298, 317, 1'b0);
    chk("mirror_hit_count", 64'(hit0_cnt), 64'd1);
    wait_done();
`endif

    // Random sprites; inputs scrambled mid-fetch to exercise the snapshot
    for (int it = 0; it < 8; it++) begin
      rom_random();
      for (int i = 0; i < NS; i++) begin
        spr_x[i]  = $urandom_range(0, 1023);
        spr_y[i]  = $urandom_range(0, 600);
        spr_en[i] = ($urandom_range(0, 3) != 0);
`ifdef SPRITE_MIRROR_EN
        spr_flip[i] = 1'($urandom_range(0, 1));
`endif
      end
      drive_sprites();
      k    = $urandom_range(0, NS - 1);
      line = spr_y[k] + $urandom_range(0, 17) - 1;
      if (line < 0) line = 0;
      start_line(line);
      for (int n = 0; n < 3; n++) step();
      for (int i = 0; i < NS; i++) begin
        spr_x[i] = $urandom_range(0, 1023);
        spr_y[i] = $urandom_range(0, 600);
      end
      drive_sprites();
      wait_done();
      start_line(line + 1);
      sweep_all_sprites();
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Schedules the single shared 16x16 sprite mask ROM (8-bit address {row[3:0],col[3:0]}, 1-bit mask, combinational) among NUM_SPR on-screen sprites.
- During each horizontal blank, fetches the 16-bit mask row of every sprite that intersects the next scanline into a shadow line buffer.
- Swaps the shadow buffer into the active buffer at the next line start.
- During active video, emits a per-sprite hit mask for the current pixel. Sits between the VGA timing generator and the pixel colour mux.

Parameters:
- NUM_SPR, 4, number of sprites sharing the ROM (1..8)
- X_W, 10, pixel X coordinate width
- Y_W, 10, line Y coordinate width

Ports:
- Clock  in  1  system/pixel clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- iLineStart  in  1  one-cycle pulse at start of horizontal blank
- iNextLine  in  Y_W  line number to prefetch; sampled on iLineStart
- iSprX  in  NUM_SPR*X_W  packed sprite left edges; sprite i at [i*X_W +: X_W]
- iSprY  in  NUM_SPR*Y_W  packed sprite top edges
- iSprEnable  in  NUM_SPR  per-sprite enable
- iPixelX  in  X_W  current pixel column
- iActive  in  1  active-video qualifier
- oRomAddress  out  8  address to the mask ROM
- iRomMask  in  1  ROM data for oRomAddress, same cycle
- oHit  out  NUM_SPR  registered per-sprite opaque bit for the current pixel
- oBusy  out  1  fetch in progress
- oDone  out  1  one-cycle pulse when the fetch for a line completes
- oOverrun  out  1  one-cycle pulse when iLineStart arrives while busy

Behaviour:
- Reset (async, Reset=0): FSM=IDLE; all outputs 0; all shadow/active valid bits 0; row buffers cleared.
- FSM states: IDLE, CHECK, FETCH, DONE.
- iLineStart in any state:
  - Copy shadow rows, shadow X and shadow valid into the active buffer.
  - If state≠IDLE: assert oOverrun for one cycle; abort the fetch; set all active valid bits to 0 instead of copying.
  - Snapshot iNextLine, iSprX, iSprY, iSprEnable; clear shadow valid bits.
  - Set sprite index i=0; go to CHECK.
- CHECK (1 cycle):
  - dy = line − SprY[i], Y_W+1-bit subtraction.
  - Hit condition: enable[i] && dy ≥ 0 && dy < 16.
  - On hit: row=dy[3:0], col=0, go to FETCH.
  - Otherwise: if i=NUM_SPR−1 go to DONE, else i++ and stay in CHECK.
- FETCH (16 cycles):
  - oRomAddress={row,col}.
  - shadowRow[i][col] ← iRomMask each cycle; col++.
  - After col=15: shadowValid[i]=1, shadowX[i]=SprX[i]; then advance i as in CHECK.
- DONE: oDone=1 for one cycle, then IDLE.
- Fetch length: worst case NUM_SPR*17+1 cycles (69 for NUM_SPR=4); must fit within hblank.
- oBusy=1 in CHECK and FETCH.
- oRomAddress holds its last value outside FETCH.
- Hit output, for each i, registered with 1-cycle latency:
  - dx = iPixelX − activeX[i], X_W+1 bits.
  - oHit[i] ← iActive && activeValid[i] && dx ≥ 0 && dx < 16 && activeRow[i][dx[3:0]].
- Sprite partly off the left edge (SprX near 0): dx is never negative for visible columns, so no wrap.
- Sprite past the right edge: columns beyond the X range never match, so no wrap-around.
- Snapshot isolation: changing iSprX/iSprY mid-fetch has no effect until the next iLineStart.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- When defined:
  - Adds input port iSprFlip [NUM_SPR-1:0], snapshotted on iLineStart.
  - For flipped sprites, FETCH drives oRomAddress={row,4'd15−col} while still writing shadowRow[i][col], giving a horizontally mirrored row.
- When undefined: port absent; no mirroring logic.

Test Plan:
- Reset=0 mid-FETCH, released 3 cycles later → oBusy, oHit, oDone all 0; FSM IDLE; no hit until the next complete fetch cycle.
- Sprite 0 at X=100, Y=50, enabled; iLineStart with iNextLine=50; ROM row 0 = 1110000000000111 (col0..15); next line start, iActive=1, sweep X=98..117 → oHit[0]=1 exactly for X=100,101,102,113,114,115, each one cycle after the pixel.
- All 4 sprites enabled, all at Y=10, line 10 → oDone 69 cycles after iLineStart; oRomAddress=0x00..0x0F four times.
- iNextLine=66 with a sprite at Y=50 (dy=16), and iNextLine=49 (dy=−1) → sprite skipped; oDone after 5 cycles; oHit stays 0.
- Second iLineStart 20 cycles after the first with 4 sprites hit → oOverrun pulses; oHit all 0 for that line; new fetch completes normally.
- SPRITE_MIRROR_EN defined, iSprFlip[0]=1, row pattern 1000000000000000 → only X=SprX+15 hits.
